// File: rtl/jk_count_driver.sv
// Excitation driver for an unresettable J-K flip-flop bank, making it a modulo-MODULUS up/down counter with load.
// Latency: control sampled at edge N updates count and bank q after edge N; j/k are combinational.
// No backpressure: a count, load or hold is applied every cycle; err flags bank divergence and is sticky.
module jk_count_driver #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] count,
  output logic             ready,
  output logic             tc,
  output logic             err
);

  typedef enum logic {CLEAR, RUN} state_t;

  // Top count value and arithmetic constants, one bit wider than the count.
  localparam logic [WIDTH:0] MAX_V  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE_V  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] ZERO_V = '0;

  state_t         state;
  state_t         state_nxt;
  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] ld_x;
  logic [WIDTH:0] nxt_x;
  logic           wrap;
  logic           unused_nxt_msb;

  assign cnt_x = {1'b0, count};
  assign ld_x  = {1'b0, load_val};

  // The result never exceeds MODULUS-1, so the extra arithmetic bit is always zero here.
  assign unused_nxt_msb = nxt_x[WIDTH];

  // Next state, next shadow value and per-stage excitation.
  always_comb begin
    state_nxt = state;
    nxt_x     = cnt_x;
    wrap      = 1'b0;
    j         = '0;
    k         = '1;
    case (state)
      CLEAR: begin
        // Force every stage to 0 regardless of its power-up value.
        state_nxt = RUN;
      end
      RUN: begin
        if (load) begin
          nxt_x = (ld_x > MAX_V) ? MAX_V : ld_x;
          // Explicit set/clear so a diverged bank is repaired by the load.
          j     = nxt_x[WIDTH-1:0];
          k     = ~nxt_x[WIDTH-1:0];
        end else begin
          if (en) begin
            if (up) begin
              if (cnt_x == MAX_V) begin
                nxt_x = ZERO_V;
                wrap  = 1'b1;
              end else begin
                nxt_x = cnt_x + ONE_V;
              end
            end else begin
              if (cnt_x == ZERO_V) begin
                nxt_x = MAX_V;
                wrap  = 1'b1;
              end else begin
                nxt_x = cnt_x - ONE_V;
              end
            end
          end
          // Toggle exactly the bits that change, hold the rest.
          j = nxt_x[WIDTH-1:0] ^ count;
          k = nxt_x[WIDTH-1:0] ^ count;
        end
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Shadow count, terminal-count pulse, ready and sticky feedback check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ready <= 1'b0;
      tc    <= 1'b0;
      err   <= 1'b0;
    end else begin
      ready <= (state_nxt == RUN);
      if (state == RUN) begin
        count <= nxt_x[WIDTH-1:0];
        tc    <= wrap;
        if (q_fb != count) begin
          err <= 1'b1;
        end
      end else begin
        tc <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jk_count_driver.md
# jk_count_driver

Excitation driver that sits directly upstream of a bank of WIDTH J-K flip-flops (clock `clk`, inputs `j`/`k`, outputs `q`/`qbar`, no reset of their own) and turns that bank into a modulo-MODULUS up/down counter with synchronous load.

- It holds a shadow copy of the count and computes per-bit `j`/`k` so the bank follows the shadow.
- It clears the unresettable bank after reset.
- It checks the bank's `q` feedback against the shadow and flags any divergence.

## Interface
- `WIDTH`, default 4: counter width, which is also the number of J-K stages driven.
- `MODULUS`, default 10: count range 0..MODULUS-1. Legal values are 2 ≤ MODULUS ≤ 2^WIDTH.
- `clk`  in  1: rising-edge clock, shared with the J-K bank.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: count enable.
- `up`  in  1: direction; 1 counts up, 0 counts down.
- `load`  in  1: synchronous load request. Takes priority over `en`.
- `load_val`  in  WIDTH: value to load.
- `q_fb`  in  WIDTH: `q` outputs of the J-K bank, bit i from stage i.
- `j`  out  WIDTH: J inputs of the bank (combinational).
- `k`  out  WIDTH: K inputs of the bank (combinational).
- `count`  out  WIDTH: shadow count (registered).
- `ready`  out  1: high when in RUN state (registered).
- `tc`  out  1: terminal-count pulse (registered).
- `err`  out  1: sticky feedback-mismatch flag (registered).

## Operation
- Two-state FSM:
  - CLEAR, entered by reset. Lasts exactly one clock edge after `rst_n` rises, then goes to RUN.
  - RUN, which persists until the next reset.
- In CLEAR, and while `rst_n` is low:
  - `j` = 0, `k` = all ones, forcing every stage to 0 regardless of its unknown initial state.
  - `en` and `load` are ignored.
- In RUN, the next shadow value `nxt` is chosen in this priority:
  - `load` = 1: `nxt` = `load_val`. If `load_val` ≥ MODULUS it saturates to MODULUS-1.
  - `en` = 1, `up` = 1: `nxt` = `count`+1, or 0 when `count` = MODULUS-1 (wrap).
  - `en` = 1, `up` = 0: `nxt` = `count`-1, or MODULUS-1 when `count` = 0 (wrap).
  - Otherwise `nxt` = `count`.
- Per-bit excitation in RUN:
  - Load cycle: `j[i]` = `nxt[i]`, `k[i]` = ~`nxt[i]` (explicit set/clear, correct even if the bank has diverged).
  - Count or hold cycle: bit changes → `j[i]` = `k[i]` = 1 (toggle); bit unchanged → `j[i]` = `k[i]` = 0 (hold).
- `j`/`k` depend only on state, `count`, `en`, `up`, `load` and `load_val`. Never on `q_fb`.
- Arithmetic is done in WIDTH+1 bits. Wrap is decided by comparison against MODULUS-1 and 0, never by natural overflow, so non-power-of-two moduli work.
- Checker: at every rising edge in RUN, if `q_fb` ≠ `count` then `err` is set. `err` stays set until `rst_n` goes low. It does not stop counting.

## Timing
- Reset values (held while `rst_n` = 0):
  - `count` = 0, `ready` = 0, `tc` = 0, `err` = 0, state = CLEAR.
  - `j` = 0, `k` = all ones.
- Reset assertion acts immediately (asynchronous), including mid-count or mid-load. Any in-flight load is discarded.
- First edge after `rst_n` rises: the bank clears, state goes to RUN, and `ready` = 1 after that edge.
  - No comparison is made at this edge.
  - `count` stays 0.
- In RUN, control inputs sampled at edge N give the new `count` and new bank `q` both visible after edge N. Latency is 1 cycle, and `count` equals `q_fb` throughout the following cycle.
- `tc` is high for exactly the one cycle after an edge at which a count wrap occurred, in either direction.
  - A load never raises `tc`, even when loading 0 or MODULUS-1.
- Simultaneous `load` and `en`: load wins; `up` is ignored.
- `en` = 0 and `load` = 0: all `j`/`k` = 0 and the bank holds.
- The `err` comparison at edge N uses the `count` value before edge N.

## Test plan
- Reset release, WIDTH=4, MODULUS=10, bank `q` randomised to 4'b1011: after 1 edge `ready` = 1 and `q_fb` = 0; `count` = 0 and `err` = 0.
- `up` = 1, `en` = 1 for 12 edges from 0: `count` goes 1..9, 0, 1, 2; `tc` is high for exactly the cycle after 9→0; `j`/`k` = 4'b1001 at 9→0 (bits 3 and 0 toggle); `err` stays 0 throughout.
- `up` = 0 from 0: `count` = 9 next cycle with `tc` = 1; `load` = 1, `en` = 1, `load_val` = 4'd14: `count` = 9 (saturated) and `tc` = 0.
- Force one bank stage to stick at 1 while counting: `err` rises at the first edge where `q_fb` ≠ `count`. It stays 1 through further counting, clears only on `rst_n` low, and the next load repairs the bank.
- Assert `rst_n` low mid-count at `count` = 6: `count`, `tc`, `err` and `ready` go to 0 immediately, and `k` = 4'b1111; after release, 1 CLEAR edge, then counting resumes from 0.
